// File: rtl/shop_pkg.sv
// Shared constants, command keys and state encoding for the shop command front-end.
// Command keys are right-justified, zero-padded ASCII, matching Verilog string literals.
package shop_pkg;

    localparam int I_A_NUM_ASCII_CHARS = 7;
    localparam int I_A_NUM_BITS        = I_A_NUM_ASCII_CHARS * 8;
    localparam int I_U_NUM_BITS        = 4;
    localparam int CNT_BITS            = $clog2(I_A_NUM_ASCII_CHARS + 1);

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] SP = 8'h20;

    localparam logic [I_A_NUM_BITS-1:0] CMD_KEY__LOGOUT  = {8'h00, "Logout"};
    localparam logic [I_A_NUM_BITS-1:0] CMD_KEY__LOGIN   = {16'h0000, "Login"};
    localparam logic [I_A_NUM_BITS-1:0] CMD_KEY__ADDUSR  = {8'h00, "AddUsr"};
    localparam logic [I_A_NUM_BITS-1:0] CMD_KEY__DELUSR  = {8'h00, "DelUsr"};
    localparam logic [I_A_NUM_BITS-1:0] CMD_KEY__ADDITEM = "AddItem";
    localparam logic [I_A_NUM_BITS-1:0] CMD_KEY__DELITEM = "DelItem";
    localparam logic [I_A_NUM_BITS-1:0] CMD_KEY__BUY     = {32'h0000_0000, "Buy"};
    localparam logic [I_A_NUM_BITS-1:0] CMD_KEY__NONE    = {24'h00_0000, "NONE"};

    typedef enum logic [2:0] {
        S_USER,
        S_SEP,
        S_CMD,
        S_EMIT,
        S_DRAIN
    } state_t;

    function automatic logic is_term(input logic [7:0] b);
        return (b == CR) || (b == LF);
    endfunction

    function automatic logic is_print(input logic [7:0] b);
        return (b >= 8'h21) && (b <= 8'h7E);
    endfunction

    function automatic logic is_hex(input logic [7:0] b);
        return ((b >= "0") && (b <= "9")) ||
               ((b >= "A") && (b <= "F")) ||
               ((b >= "a") && (b <= "f"));
    endfunction

    // Letters have low nibble 1..6 in both cases, so +9 yields 10..15.
    function automatic logic [I_U_NUM_BITS-1:0] hex_val(input logic [7:0] b);
        return (b <= "9") ? b[3:0] : b[3:0] + 4'd9;
    endfunction

endpackage

// File: rtl/shop_key_match_v.sv
// Combinational lookup: flags whether a command word is one of the known shop keys.
module shop_key_match_v
    import shop_pkg::*;
(
    input  logic [I_A_NUM_BITS-1:0] key,
    output logic                    hit
);

    assign hit = (key == CMD_KEY__LOGOUT)  || (key == CMD_KEY__LOGIN)   ||
                 (key == CMD_KEY__ADDUSR)  || (key == CMD_KEY__DELUSR)  ||
                 (key == CMD_KEY__ADDITEM) || (key == CMD_KEY__DELITEM) ||
                 (key == CMD_KEY__BUY);

endmodule

// File: rtl/shop_cmd_rx_v.sv
// Byte-serial "<hex user> <command><CR|LF>" line receiver feeding shop_v.
// Optional SHOP_CMD_KEY_CHECK_EN replaces unknown commands with "NONE" and flags o_err.
module shop_cmd_rx_v
    import shop_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_valid,
    input  logic [7:0]              i_byte,
    output logic                    o_ready,
    output logic                    o_rdy,
    output logic [I_U_NUM_BITS-1:0] o_u,
    output logic [I_A_NUM_BITS-1:0] o_a,
    output logic                    o_err
);

    state_t                  state;
    logic [I_U_NUM_BITS-1:0] user_q;
    logic [I_A_NUM_BITS-1:0] shift_q;
    logic [CNT_BITS-1:0]     cnt_q;
    logic                    accept;
    logic                    key_hit;

    assign accept = i_valid & o_ready;

`ifdef SHOP_CMD_KEY_CHECK_EN
    shop_key_match_v u_key_match (
        .key (shift_q),
        .hit (key_hit)
    );
`else
    assign key_hit = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= S_USER;
            user_q  <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            o_ready <= 1'b0;
            o_rdy   <= 1'b0;
            o_err   <= 1'b0;
            o_u     <= '0;
            o_a     <= '0;
        end else begin
            // Strobes default low; o_ready is only dropped for the emit bubble.
            o_rdy   <= 1'b0;
            o_err   <= 1'b0;
            o_ready <= 1'b1;

            if (state == S_EMIT) begin
                state <= S_USER;
            end else if (accept) begin
                case (state)
                    S_USER: begin
                        if (is_hex(i_byte)) begin
                            user_q  <= hex_val(i_byte);
                            shift_q <= '0;
                            cnt_q   <= '0;
                            state   <= S_SEP;
                        end else if (!is_term(i_byte)) begin
                            o_err <= 1'b1;
                            state <= S_DRAIN;
                        end
                    end

                    S_SEP: begin
                        if (i_byte == SP) begin
                            state <= S_CMD;
                        end else begin
                            o_err <= 1'b1;
                            state <= is_term(i_byte) ? S_USER : S_DRAIN;
                        end
                    end

                    S_CMD: begin
                        if (is_print(i_byte)) begin
                            if (cnt_q < CNT_BITS'(I_A_NUM_ASCII_CHARS)) begin
                                shift_q <= {shift_q[I_A_NUM_BITS-9:0], i_byte};
                                cnt_q   <= cnt_q + CNT_BITS'(1);
                            end else begin
                                o_err <= 1'b1;
                                state <= S_DRAIN;
                            end
                        end else if (is_term(i_byte)) begin
                            if (cnt_q == '0) begin
                                o_err <= 1'b1;
                                state <= S_USER;
                            end else begin
                                state   <= S_EMIT;
                                o_rdy   <= 1'b1;
                                o_ready <= 1'b0;
                                o_u     <= user_q;
                                if (key_hit) begin
                                    o_a <= shift_q;
                                end else begin
                                    o_a   <= CMD_KEY__NONE;
                                    o_err <= 1'b1;
                                end
                            end
                        end else begin
                            o_err <= 1'b1;
                            state <= S_DRAIN;
                        end
                    end

                    S_DRAIN: begin
                        if (is_term(i_byte)) state <= S_USER;
                    end

                    default: state <= S_USER;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shop_cmd_rx_v.sv
// Self-checking bench for shop_cmd_rx_v: directed lines from the test plan plus
// random lines, compared against a string-level model of the line grammar.
module tb_shop_cmd_rx_v;

    logic        i_clk;
    logic        i_reset;
    logic        i_valid;
    logic [7:0]  i_byte;
    logic        o_ready;
    logic        o_rdy;
    logic [3:0]  o_u;
    logic [55:0] o_a;
    logic        o_err;

    shop_cmd_rx_v dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_byte  (i_byte),
        .o_ready (o_ready),
        .o_rdy   (o_rdy),
        .o_u     (o_u),
        .o_a     (o_a),
        .o_err   (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int line_no  = 0;

    int rdy_cnt, err_cnt, rdy_err_cnt, ready_bad;
    bit mon_en = 1'b0;

    logic [3:0]  last_u = '0;
    logic [55:0] last_a = '0;

    string keys [7] = '{"Logout", "Login", "AddUsr", "DelUsr", "AddItem", "DelItem", "Buy"};

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (o_rdy) rdy_cnt++;
            if (o_err) err_cnt++;
            if (o_rdy && o_err) rdy_err_cnt++;
            if (!o_ready && !o_rdy) ready_bad++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [55:0] pack(input string c);
        logic [55:0] a = '0;
        int n = c.len();
        for (int i = 0; i < n; i++) a[8*(n-1-i) +: 8] = c[i];
        return a;
    endfunction

    function automatic int hex_of(input int c);
        if (c >= 48 && c <= 57)  return c - 48;
        if (c >= 65 && c <= 70)  return c - 55;
        if (c >= 97 && c <= 102) return c - 87;
        return -1;
    endfunction

    // Line grammar model: s holds one line whose last char is its only terminator.
    function automatic void model(input string s, output int er, output int rd,
                                  output logic [3:0] u, output logic [55:0] a);
        int n = s.len() - 1;
        string cmd;
        er = 0; rd = 0; u = last_u; a = last_a;
        if (n == 0) return;
        if (hex_of(int'(s[0])) < 0) begin er = 1; return; end
        if (n < 2 || s[1] != 8'h20) begin er = 1; return; end
        if (n - 2 < 1 || n - 2 > 7) begin er = 1; return; end
        for (int i = 2; i < n; i++)
            if (int'(s[i]) < 33 || int'(s[i]) > 126) er = 1;
        if (er != 0) return;
        cmd = s.substr(2, n - 1);
        rd = 1;
        u  = 4'(hex_of(int'(s[0])));
        a  = pack(cmd);
`ifdef SHOP_CMD_KEY_CHECK_EN
        begin
            bit known = 1'b0;
            foreach (keys[k]) if (keys[k] == cmd) known = 1'b1;
            if (!known) begin er = 1; a = pack("NONE"); end
        end
`endif
    endfunction

    // gap: 0 back-to-back, 1 one idle cycle before each byte, 2 random 0..2 idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
        bit ok = 1'b0;
        repeat (idle) begin
            i_valid = 1'b0;
            i_byte  = 8'($urandom);
            @(negedge i_clk);
        end
        i_valid = 1'b1;
        i_byte  = b;
        for (int t = 0; t < 20 && !ok; t++) begin
            ok = o_ready;
            @(negedge i_clk);
        end
        if (!ok) check("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic run_line(input string s, input int gap);
        int er, rd;
        logic [3:0]  u;
        logic [55:0] a;
        string tag;
        line_no++;
        tag = $sformatf("line%0d", line_no);
        model(s, er, rd, u, a);
        rdy_cnt = 0; err_cnt = 0; rdy_err_cnt = 0;
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], gap);
            if (i == s.len() - 1) begin
                check({tag, ":rdy_latency"}, 64'(o_rdy), 64'(rd));
                check({tag, ":ready_in_emit"}, 64'(o_ready), 64'(rd == 0));
            end
        end
        i_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        check({tag, ":rdy_count"}, 64'(rdy_cnt), 64'(rd));
        check({tag, ":err_count"}, 64'(err_cnt), 64'(er));
        check({tag, ":rdy_with_err"}, 64'(rdy_err_cnt), 64'(rd != 0 && er != 0));
        check({tag, ":o_u"}, 64'(o_u), 64'(u));
        check({tag, ":o_a"}, 64'(o_a), 64'(a));
        last_u = u;
        last_a = a;
    endtask

    function automatic string rand_line();
        string hexs = "0123456789ABCDEFabcdef";
        string s;
        int kind = $urandom_range(0, 5);
        byte term = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
        byte uc = hexs[$urandom_range(0, 21)];
        case (kind)
            0, 1, 2: s = {$sformatf("%c", uc), " ", keys[$urandom_range(0, 6)]};
            3: begin
                s = $sformatf("%c ", uc);
                repeat ($urandom_range(1, 9)) s = $sformatf("%s%c", s, 8'($urandom_range(33, 126)));
            end
            4: s = $sformatf("%c Buy", 8'($urandom_range(71, 90)));
            default: s = ($urandom_range(0, 1) != 0) ? $sformatf("%cLogin", uc) : $sformatf("%c Lo in", uc);
        endcase
        return $sformatf("%s%c", s, term);
    endfunction

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_byte  = 8'h00;
        rdy_cnt = 0; err_cnt = 0; rdy_err_cnt = 0; ready_bad = 0;
        repeat (3) @(negedge i_clk);
        check("reset:o_rdy",   64'(o_rdy),   64'd0);
        check("reset:o_err",   64'(o_err),   64'd0);
        check("reset:o_u",     64'(o_u),     64'd0);
        check("reset:o_a",     64'(o_a),     64'd0);
        check("reset:o_ready", 64'(o_ready), 64'd0);
        i_reset = 1'b0;
        @(negedge i_clk);
        check("release:o_ready", 64'(o_ready), 64'd1);
        mon_en = 1'b1;

        run_line("4 Login\n", 0);
        check("login:o_a_literal", 64'(o_a), 64'h0000_4C6F_6769_6E);
        run_line("5 AddItem\r", 1);
        repeat (4) @(negedge i_clk);
        check("hold:o_u", 64'(o_u), 64'd5);
        check("hold:o_a", 64'(o_a), 64'(pack("AddItem")));
        run_line("6 sdfsdfXX\n", 0);
        run_line("7 Buy\n", 0);
        check("buy:o_a_literal", 64'(o_a), 64'h0000_0000_4275_79);
        run_line("G Login\n", 0);
        run_line("4Login\n", 0);
        run_line("4 \n", 0);
        run_line("4\r", 0);
        run_line("\r", 0);
        run_line("F Logout\n", 2);
        run_line("2 hi\n", 0);
`ifdef SHOP_CMD_KEY_CHECK_EN
        check("hi:o_a_literal", 64'(o_a), 64'h0000_004E_4F4E_45);
`else
        check("hi:o_a_literal", 64'(o_a), 64'h0000_0000_0068_69);
`endif
        run_line("A DelItem\n", 0);

        // Asynchronous reset in the middle of a line.
        for (int i = 0; i < 7; i++) send_byte(byte'("3 DelUs" >> (8 * (6 - i))), 0);
        i_valid = 1'b0;
        mon_en  = 1'b0;
        #2 i_reset = 1'b1;
        #1;
        check("midreset:o_u",     64'(o_u),     64'd0);
        check("midreset:o_a",     64'(o_a),     64'd0);
        check("midreset:o_rdy",   64'(o_rdy),   64'd0);
        check("midreset:o_err",   64'(o_err),   64'd0);
        check("midreset:o_ready", 64'(o_ready), 64'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        check("midrelease:o_ready_low", 64'(o_ready), 64'd0);
        @(negedge i_clk);
        check("midrelease:o_ready_high", 64'(o_ready), 64'd1);
        last_u = '0;
        last_a = '0;
        mon_en = 1'b1;
        run_line("3 DelUsr\n", 0);

        for (int r = 0; r < 40; r++) run_line(rand_line(), int'($urandom_range(0, 2)));

        check("ready_low_outside_emit", 64'(ready_bad), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shop_cmd_rx_v.md
Name: shop_cmd_rx_v

Overview:
- Upstream front-end for shop_v. Receives a byte-serial ASCII command line of the form `<hex user digit><space><command>` followed by CR or LF.
- Assembles each valid line into the shop_v input word and presents it on o_u/o_a with a single-cycle o_rdy strobe, which drives shop_v i_rdy directly.
- Malformed lines are flagged on o_err and dropped. Nothing is forwarded to shop_v for them.

Parameters:
- I_A_NUM_ASCII_CHARS, 7: maximum command length in chars; must fit the longest CMD_KEY.
- I_A_NUM_BITS, I_A_NUM_ASCII_CHARS*8: width of o_a.
- I_U_NUM_BITS, 4: width of o_u; the user value is at most 15.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  i_byte is valid this cycle.
- i_byte  in  8  ASCII character.
- o_ready  out  1  byte accepted when i_valid and o_ready are both 1.
- o_rdy  out  1  one-cycle strobe: o_u and o_a hold a new command.
- o_u  out  I_U_NUM_BITS  user id of the last emitted command.
- o_a  out  I_A_NUM_BITS  command string, right-justified and zero-padded on the left, same encoding as a Verilog string literal (e.g. "Login" = 0x00004C6F67696E).
- o_err  out  1  one-cycle strobe: framing error detected.

Behaviour:
- Reset (asynchronous):
  - State goes to S_USER; char count = 0; shift reg = 0.
  - o_rdy = 0, o_err = 0, o_u = 0, o_a = 0.
  - o_ready = 0 while i_reset is high and 1 from the first clock after release.
  - Reset mid-line discards the partial line with no strobe.
- Accept: a byte is consumed only on a clock with i_valid & o_ready. Bytes with i_valid low are ignored.
- S_USER:
  - CR (0x0D) or LF (0x0A): ignored, stay in S_USER.
  - '0'-'9', 'A'-'F', 'a'-'f': latch the value into the user reg, clear shift reg and count, go to S_SEP.
  - Any other byte: pulse o_err, go to S_DRAIN.
- S_SEP:
  - 0x20: go to S_CMD.
  - CR/LF: pulse o_err, go to S_USER.
  - Any other byte: pulse o_err, go to S_DRAIN.
- S_CMD:
  - Printable 0x21-0x7E with count < I_A_NUM_ASCII_CHARS: shift reg = {shift[I_A_NUM_BITS-9:0], byte}; count++.
  - Printable byte with count already at maximum (8th char): pulse o_err, go to S_DRAIN.
  - CR/LF with count = 0: pulse o_err, go to S_USER.
  - CR/LF with count > 0: go to S_EMIT; o_u <= user reg and o_a <= shift reg on that same edge.
  - 0x20 or any other non-printable byte: pulse o_err, go to S_DRAIN.
- S_EMIT:
  - o_rdy = 1 for exactly one cycle; o_ready = 0.
  - Unconditionally go to S_USER next cycle.
  - Latency: terminator accept edge to o_rdy high is 1 clock.
- S_DRAIN: consume and discard bytes until CR/LF, then go to S_USER. No strobes.
- Output stability: o_u/o_a are updated only on entry to S_EMIT and hold otherwise. An errored line never modifies them.
- o_err is registered and asserts the cycle after the offending byte is accepted. It never coincides with o_rdy unless SHOP_CMD_KEY_CHECK_EN is defined.
- Throughput: one byte per clock, except the single S_EMIT bubble.

Optional Feature:
- Macro: SHOP_CMD_KEY_CHECK_EN.
- Defined:
  - On S_CMD to S_EMIT, the shift reg is compared against Logout, Login, AddUsr, DelUsr, AddItem, DelItem, Buy.
  - Match: forward unchanged.
  - No match: o_a <= CMD_KEY__NONE ("NONE"), and o_err pulses in the same cycle as o_rdy.
- Undefined: no comparison; any 1-7 printable chars are forwarded verbatim, and o_err never accompanies o_rdy.

Decomposition:
- Shared package shop_pkg holds:
  - I_A_NUM_ASCII_CHARS, I_U_NUM_BITS, I_A_NUM_BITS;
  - all CMD_KEY__* constants;
  - ASCII constants CR, LF, SP;
  - state encodings.
- Sub-module shop_key_match_v: combinational; takes the I_A_NUM_BITS word and returns a hit flag. Instantiated only under SHOP_CMD_KEY_CHECK_EN.

Test Plan:
- Reset then bytes "4 Login\n":
  - o_rdy pulses once, 1 clk after '\n' is accepted;
  - o_u=4, o_a=0x00004C6F67696E, o_err=0;
  - o_ready low only during the S_EMIT cycle.
- "5 AddItem\r" with i_valid gapped every other cycle: o_u=5, o_a="AddItem"; values hold after o_rdy until the next valid line.
- "6 sdfsdfXX\n" (8 chars): o_err pulses on the 8th char; no o_rdy; o_u/o_a keep previous values; next line "7 Buy\n" gives o_u=7, o_a=0x00000000427579.
- "G Login\n", "4Login\n", "4 \n": each gives one o_err pulse and no o_rdy; the following "F Logout\n" emits o_u=15.
- Assert i_reset mid-way through "3 DelUs": all outputs go to 0 asynchronously; after release "3 DelUsr\n" emits correctly.
- With SHOP_CMD_KEY_CHECK_EN, "2 hi\n": o_rdy and o_err together, o_a="NONE" (0x0000004E4F4E45). Without the macro: o_a=0x00000000006869, o_err=0.
